// File: rtl/timekeeper_ctrl.sv
// 24-hour timekeeping controller: counts seconds/minutes/hours on the tick in RUN
// and lets the user step hours or minutes through a three-state set-mode FSM.
module timekeeper_ctrl #(
  parameter int HOURS_MOD = 24,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Tick,
  input  logic       ModeBtn,
  input  logic       IncBtn,
  output logic [4:0] Hours,
  output logic [5:0] Minutes,
  output logic [5:0] Seconds,
  output logic [1:0] Mode,
  output logic       Blink,
  output logic       Midnight
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam logic [4:0] HOUR_LAST = 5'(HOURS_MOD - 1);
  localparam logic [5:0] MS_LAST   = 6'd59;

  mode_e      mode_q, mode_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       mid_q, mid_d;

  logic sec_wrap, min_wrap, hour_wrap;

  assign sec_wrap  = (sec_q == MS_LAST);
  assign min_wrap  = (min_q == MS_LAST);
  assign hour_wrap = (hour_q == HOUR_LAST);

  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    mid_d   = 1'b0;

    // The RUN tick is counted even when ModeBtn moves us out of RUN this cycle.
    if (mode_q == RUN && Tick) begin
      sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) begin
        min_d = min_wrap ? 6'd0 : min_q + 6'd1;
        if (min_wrap) begin
          hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
        end
      end
      mid_d = sec_wrap && min_wrap && hour_wrap;
    end

    if (ModeBtn) begin
      blink_d = 1'b0;
      case (mode_q)
        RUN:      mode_d = SET_HOUR;
        SET_HOUR: mode_d = SET_MIN;
        SET_MIN: begin
          mode_d = RUN;
          sec_d  = 6'd0;
        end
        default:  mode_d = RUN;
      endcase
    end else begin
      case (mode_q)
        SET_HOUR: begin
          if (Tick)   blink_d = ~blink_q;
          if (IncBtn) hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
        end
        SET_MIN: begin
          if (Tick)   blink_d = ~blink_q;
          if (IncBtn) min_d = min_wrap ? 6'd0 : min_q + 6'd1;
        end
        default: blink_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      mode_q  <= RUN;
      hour_q  <= 5'(INIT_HOUR);
      min_q   <= 6'(INIT_MIN);
      sec_q   <= 6'd0;
      blink_q <= 1'b0;
      mid_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
      mid_q   <= mid_d;
    end
  end

  assign Hours    = hour_q;
  assign Minutes  = min_q;
  assign Seconds  = sec_q;
  assign Mode     = mode_q;
  assign Blink    = blink_q;
  assign Midnight = mid_q;

endmodule
